// File: rtl/run_sequencer.sv
// Iteration sequencer for the replica annealing array: sweeps the opt stages, drains the pipeline, then runs the exp unit.
// Optional build macro RUN_SEQUENCER_ABORT_EN adds an abort input that returns the sequencer to IDLE without a done pulse.
module run_sequencer #(
    parameter int base_log  = 4,
    parameter int drain_cyc = 3,
    parameter int exp_cyc   = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         run_times,
    input  logic                or_en_i,
    input  logic                tw_en_i,
    input  logic [16:0]         recip_i,
`ifdef RUN_SEQUENCER_ABORT_EN
    input  logic                abort,
`endif
    output logic                busy,
    output logic                done,
    output logic                opt_run,
    output logic                or_opt_en,
    output logic                tw_opt_en,
    output logic [base_log-1:0] or_rn_base_id,
    output logic [base_log-1:0] or_dd_base_id,
    output logic [base_log-1:0] or_rp_base_id,
    output logic [base_log-1:0] or_ex_base_id,
    output logic [base_log-1:0] tw_rn_base_id,
    output logic [base_log-1:0] tw_dd_base_id,
    output logic [base_log-1:0] tw_rp_base_id,
    output logic [base_log-1:0] tw_ex_base_id,
    output logic                exp_init,
    output logic                exp_run,
    output logic                exp_fin,
    output logic [16:0]         exp_recip
);

    localparam int base_num = 2 ** base_log;
    localparam logic [base_log-1:0] half_c     = base_log'(base_num / 2);
    localparam logic [base_log-1:0] bc_last_c  = base_log'(base_num - 1);
    localparam logic [base_log-1:0] one_c      = base_log'(1);
    localparam logic [7:0]          drain_last_c = 8'(drain_cyc - 1);
    localparam logic [7:0]          exp_last_c   = 8'(exp_cyc - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OPT      = 3'd1,
        DRAIN    = 3'd2,
        EXP_INIT = 3'd3,
        EXP_RUN  = 3'd4,
        EXP_FIN  = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [base_log-1:0] bc_r;
    logic [base_log-1:0] bc_nx_s;
    logic [7:0]          cyc_r;
    logic [7:0]          cyc_nx_s;
    logic [31:0]         iter_r;
    logic [31:0]         iter_nx_s;
    logic                or_en_r;
    logic                tw_en_r;
    logic                or_en_s;
    logic                tw_en_s;
    logic                accept_s;
    logic                abort_s;
    logic                active_nx_s;
    logic                sweep_nx_s;

`ifdef RUN_SEQUENCER_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign accept_s = (state_r == IDLE) && start;
    // Enables seen by the strobes on the accepting edge come straight from the inputs.
    assign or_en_s  = accept_s ? or_en_i : or_en_r;
    assign tw_en_s  = accept_s ? tw_en_i : tw_en_r;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; abort overrides every non-idle transition.
    always_comb begin
        next_state_s = state_r;
        if (abort_s && (state_r != IDLE)) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        next_state_s = (run_times != 32'd0) ? OPT : DONE;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                OPT: begin
                    if (bc_r == bc_last_c) begin
                        next_state_s = (drain_cyc == 0) ? EXP_INIT : DRAIN;
                    end else begin
                        next_state_s = OPT;
                    end
                end
                DRAIN: begin
                    if (cyc_r == drain_last_c) begin
                        next_state_s = EXP_INIT;
                    end else begin
                        next_state_s = DRAIN;
                    end
                end
                EXP_INIT: next_state_s = EXP_RUN;
                EXP_RUN: begin
                    if (cyc_r == exp_last_c) begin
                        next_state_s = EXP_FIN;
                    end else begin
                        next_state_s = EXP_RUN;
                    end
                end
                EXP_FIN: begin
                    // The counter is still undecremented here, so 1 means this was the last pass.
                    if (iter_r != 32'd1) begin
                        next_state_s = OPT;
                    end else begin
                        next_state_s = DONE;
                    end
                end
                DONE:    next_state_s = IDLE;
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Next values of the base, phase and iteration counters.
    always_comb begin
        bc_nx_s   = bc_r;
        cyc_nx_s  = 8'd0;
        iter_nx_s = iter_r;
        if ((next_state_s == OPT) && (state_r != OPT)) begin
            bc_nx_s = {base_log{1'b0}};
        end else if ((state_r == OPT) || (state_r == DRAIN)) begin
            bc_nx_s = bc_r + one_c;
        end else begin
            bc_nx_s = bc_r;
        end
        if ((next_state_s == state_r) && ((state_r == DRAIN) || (state_r == EXP_RUN))) begin
            cyc_nx_s = cyc_r + 8'd1;
        end else begin
            cyc_nx_s = 8'd0;
        end
        if (accept_s) begin
            iter_nx_s = run_times;
        end else if (state_r == EXP_FIN) begin
            iter_nx_s = iter_r - 32'd1;
        end else begin
            iter_nx_s = iter_r;
        end
    end

    // Counter and latched-configuration registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bc_r    <= {base_log{1'b0}};
            cyc_r   <= 8'd0;
            iter_r  <= 32'd0;
            or_en_r <= 1'b0;
            tw_en_r <= 1'b0;
        end else begin
            bc_r    <= bc_nx_s;
            cyc_r   <= cyc_nx_s;
            iter_r  <= iter_nx_s;
            or_en_r <= or_en_s;
            tw_en_r <= tw_en_s;
        end
    end

    assign active_nx_s = (next_state_s != IDLE) && (next_state_s != DONE);
    assign sweep_nx_s  = (next_state_s == OPT) || (next_state_s == DRAIN);

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            opt_run       <= 1'b0;
            or_opt_en     <= 1'b0;
            tw_opt_en     <= 1'b0;
            exp_init      <= 1'b0;
            exp_run       <= 1'b0;
            exp_fin       <= 1'b0;
            exp_recip     <= 17'd0;
            or_rn_base_id <= {base_log{1'b0}};
            or_dd_base_id <= {base_log{1'b0}};
            or_rp_base_id <= {base_log{1'b0}};
            or_ex_base_id <= {base_log{1'b0}};
            tw_rn_base_id <= {base_log{1'b0}};
            tw_dd_base_id <= {base_log{1'b0}};
            tw_rp_base_id <= {base_log{1'b0}};
            tw_ex_base_id <= {base_log{1'b0}};
        end else begin
            busy      <= active_nx_s;
            done      <= (next_state_s == DONE);
            opt_run   <= (next_state_s == OPT);
            or_opt_en <= (next_state_s == OPT) && or_en_s;
            tw_opt_en <= (next_state_s == OPT) && tw_en_s;
            exp_init  <= (next_state_s == EXP_INIT);
            exp_run   <= (next_state_s == EXP_RUN);
            exp_fin   <= (next_state_s == EXP_FIN);
            exp_recip <= accept_s ? recip_i : exp_recip;
            if (sweep_nx_s) begin
                or_rn_base_id <= bc_nx_s;
                or_dd_base_id <= bc_nx_s - one_c;
                or_rp_base_id <= bc_nx_s - base_log'(2);
                or_ex_base_id <= bc_nx_s - base_log'(3);
                tw_rn_base_id <= bc_nx_s + half_c;
                tw_dd_base_id <= bc_nx_s - one_c + half_c;
                tw_rp_base_id <= bc_nx_s - base_log'(2) + half_c;
                tw_ex_base_id <= bc_nx_s - base_log'(3) + half_c;
            end else begin
                or_rn_base_id <= or_rn_base_id;
                or_dd_base_id <= or_dd_base_id;
                or_rp_base_id <= or_rp_base_id;
                or_ex_base_id <= or_ex_base_id;
                tw_rn_base_id <= tw_rn_base_id;
                tw_dd_base_id <= tw_dd_base_id;
                tw_rp_base_id <= tw_rp_base_id;
                tw_ex_base_id <= tw_ex_base_id;
            end
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed self-checking bench for run_sequencer at default parameters (16 replicas, 38-cycle iterations).
module tb_run_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] run_times;
    logic        or_en_i;
    logic        tw_en_i;
    logic [16:0] recip_i;
    logic        abort;
    logic        busy, done, opt_run, or_opt_en, tw_opt_en;
    logic [3:0]  or_rn, or_dd, or_rp, or_ex, tw_rn, tw_dd, tw_rp, tw_ex;
    logic        exp_init, exp_run, exp_fin;
    logic [16:0] exp_recip;

    int n_cmp = 0;
    int n_err = 0;

    // Window statistics filled in by observe().
    int opt_cnt, run_cnt, init_cnt, fin_cnt, done_cnt, multi_cnt, tw_cnt, recip_bad, rise_n;
    int done_idx, init_idx, fin_idx, busy_at_done;
    int rise_idx [3];
    int rn5, tw5, rn15;
    int inject_k = -1;
    int recip_k  = -1;
    logic [16:0] recip_new;
    logic [16:0] recip_exp;

    always #5 clk = ~clk;

    run_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .run_times(run_times),
        .or_en_i(or_en_i), .tw_en_i(tw_en_i), .recip_i(recip_i),
`ifdef RUN_SEQUENCER_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .opt_run(opt_run), .or_opt_en(or_opt_en), .tw_opt_en(tw_opt_en),
        .or_rn_base_id(or_rn), .or_dd_base_id(or_dd), .or_rp_base_id(or_rp), .or_ex_base_id(or_ex),
        .tw_rn_base_id(tw_rn), .tw_dd_base_id(tw_dd), .tw_rp_base_id(tw_rp), .tw_ex_base_id(tw_ex),
        .exp_init(exp_init), .exp_run(exp_run), .exp_fin(exp_fin), .exp_recip(exp_recip)
    );

    task automatic check_eq(input string tag, input longint obs, input longint exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Samples n cycles starting with the current one, then advances one clock per sample.
    task automatic observe(input int n);
        logic prev_opt;
        opt_cnt = 0; run_cnt = 0; init_cnt = 0; fin_cnt = 0; done_cnt = 0;
        multi_cnt = 0; tw_cnt = 0; recip_bad = 0; rise_n = 0;
        done_idx = -1; init_idx = -1; fin_idx = -1; busy_at_done = -1;
        rn5 = -1; tw5 = -1; rn15 = -1;
        prev_opt = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (opt_run) opt_cnt++;
            if (opt_run && !prev_opt) begin
                if (rise_n < 3) rise_idx[rise_n] = k;
                rise_n++;
            end
            prev_opt = opt_run;
            if (exp_run) run_cnt++;
            if (exp_init) begin init_cnt++; if (init_idx < 0) init_idx = k; end
            if (exp_fin) begin fin_cnt++; if (fin_idx < 0) fin_idx = k; end
            if (done) begin
                done_cnt++;
                if (done_idx < 0) begin done_idx = k; busy_at_done = int'(busy); end
            end
            if ((int'(exp_init) + int'(exp_run) + int'(exp_fin)) > 1) multi_cnt++;
            if (tw_opt_en) tw_cnt++;
            if (exp_recip != recip_exp) recip_bad++;
            if (k == 5)  begin rn5 = int'(or_rn); tw5 = int'(tw_rn); end
            if (k == 15) rn15 = int'(or_rn);
            start = (k == inject_k);
            if (k == recip_k) recip_i = recip_new;
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; run_times = 32'd0; or_en_i = 1'b0; tw_en_i = 1'b0;
        recip_i = 17'd0; abort = 1'b0; recip_new = 17'd0; recip_exp = 17'd0;
        tick(); tick(); tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_opt_run", opt_run, 0);
        check_eq("rst_exp_recip", exp_recip, 0);
        check_eq("rst_or_dd", or_dd, 0);

        // Single iteration with both enables; a second start during the run must be ignored.
        reset = 1'b1;
        start = 1'b1; run_times = 32'd1; or_en_i = 1'b1; tw_en_i = 1'b1; recip_i = 17'h1ABCD;
        tick();
        start = 1'b0; run_times = 32'd5;
        check_eq("opt0_busy", busy, 1);
        check_eq("opt0_or_opt_en", or_opt_en, 1);
        check_eq("opt0_tw_opt_en", tw_opt_en, 1);
        check_eq("opt0_or_rn", or_rn, 0);
        check_eq("opt0_or_dd", or_dd, 15);
        check_eq("opt0_or_rp", or_rp, 14);
        check_eq("opt0_or_ex", or_ex, 13);
        check_eq("opt0_tw_rn", tw_rn, 8);
        check_eq("opt0_tw_dd", tw_dd, 7);
        check_eq("opt0_tw_rp", tw_rp, 6);
        check_eq("opt0_tw_ex", tw_ex, 5);
        check_eq("opt0_exp_recip", exp_recip, 17'h1ABCD);
        recip_exp = 17'h1ABCD; inject_k = 10;
        observe(60);
        inject_k = -1;
        check_eq("t1_opt_cycles", opt_cnt, 16);
        check_eq("t1_or_rn_k5", rn5, 5);
        check_eq("t1_tw_rn_k5", tw5, 13);
        check_eq("t1_or_rn_k15", rn15, 15);
        check_eq("t1_init_idx", init_idx, 19);
        check_eq("t1_exp_run_cycles", run_cnt, 17);
        check_eq("t1_fin_idx", fin_idx, 37);
        check_eq("t1_done_idx", done_idx, 38);
        check_eq("t1_done_cnt", done_cnt, 1);
        check_eq("t1_busy_at_done", busy_at_done, 0);
        check_eq("t1_multi_strobe", multi_cnt, 0);
        check_eq("t1_recip_hold", recip_bad, 0);
        check_eq("t1_idle_busy", busy, 0);

        // Zero iterations go straight to done.
        start = 1'b1; run_times = 32'd0;
        tick();
        start = 1'b0;
        observe(10);
        check_eq("t2_done_idx", done_idx, 0);
        check_eq("t2_done_cnt", done_cnt, 1);
        check_eq("t2_busy_at_done", busy_at_done, 0);
        check_eq("t2_opt_cycles", opt_cnt, 0);

        // Three back-to-back iterations, two-opt disabled, reciprocal changed mid-run.
        start = 1'b1; run_times = 32'd3; or_en_i = 1'b1; tw_en_i = 1'b0; recip_i = 17'h00123;
        tick();
        start = 1'b0; tw_en_i = 1'b1;
        recip_exp = 17'h00123; recip_k = 50; recip_new = 17'h1FFFF;
        observe(130);
        recip_k = -1;
        check_eq("t3_opt_rises", rise_n, 3);
        check_eq("t3_rise0", rise_idx[0], 0);
        check_eq("t3_rise1", rise_idx[1], 38);
        check_eq("t3_rise2", rise_idx[2], 76);
        check_eq("t3_opt_cycles", opt_cnt, 48);
        check_eq("t3_exp_run_cycles", run_cnt, 51);
        check_eq("t3_done_idx", done_idx, 114);
        check_eq("t3_done_cnt", done_cnt, 1);
        check_eq("t3_tw_opt_en", tw_cnt, 0);
        check_eq("t3_recip_hold", recip_bad, 0);
        check_eq("t3_multi_strobe", multi_cnt, 0);

        // Asynchronous reset during EXP_RUN, then a clean run.
        start = 1'b1; run_times = 32'd2; recip_i = 17'h00777; tw_en_i = 1'b1;
        tick();
        start = 1'b0; recip_exp = 17'h00777;
        observe(25);
        check_eq("t4_in_exp_run", exp_run, 1);
        #1 reset = 1'b0;
        #1;
        check_eq("t4_rst_exp_run", exp_run, 0);
        check_eq("t4_rst_busy", busy, 0);
        check_eq("t4_rst_recip", exp_recip, 0);
        tick(); tick();
        reset = 1'b1;
        start = 1'b1; run_times = 32'd1; recip_i = 17'h00042;
        tick();
        start = 1'b0; recip_exp = 17'h00042;
        check_eq("t4_opt0_or_dd", or_dd, 15);
        observe(50);
        check_eq("t4_opt_cycles", opt_cnt, 16);
        check_eq("t4_exp_run_cycles", run_cnt, 17);
        check_eq("t4_done_idx", done_idx, 38);
        check_eq("t4_done_cnt", done_cnt, 1);

`ifdef RUN_SEQUENCER_ABORT_EN
        // Abort in OPT cycle 5 returns to idle with no done pulse.
        start = 1'b1; run_times = 32'd2;
        tick();
        start = 1'b0;
        observe(5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("t5_abort_opt_run", opt_run, 0);
        check_eq("t5_abort_busy", busy, 0);
        observe(50);
        check_eq("t5_abort_done", done_cnt, 0);
        check_eq("t5_abort_opt", opt_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
